alu_rs: RTL
===========

# alu_rs

Reservation station and single-issue integer ALU for the out-of-order core. Accepts calculation-class instructions (LUI, AUIPC, register-register and register-immediate arithmetic, logic, shift, compare) from issue. Holds them until both operands are ready, snooping the common data bus (CDB). Executes one instruction per cycle and broadcasts the tagged result on its own CDB port to the ROB, the load/store buffer and itself.

## Interface
- RS_SIZE, 8, number of station entries (power of two)
- TAG_W, 4, ROB index width
- DATA_W, 32, operand/result width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; 0 freezes all state
- clear  in  1  misprediction flush, synchronous
- issue_valid  in  1  issue request this cycle
- issue_type  in  `INST_TYPE_WIDTH`  decoded instruction type
- issue_vj, issue_vk  in  DATA_W  operand values (valid when matching q*_pend=0)
- issue_qj_pend, issue_qk_pend  in  1  operand still awaiting producer
- issue_qj, issue_qk  in  TAG_W  producer ROB tags
- issue_imm, issue_pc  in  DATA_W  immediate, instruction PC
- issue_dest  in  TAG_W  destination ROB tag
- full  out  1  no free entry (combinational from entry valid bits)
- cdb_in_valid  in  1  external broadcast valid
- cdb_in_tag  in  TAG_W  external broadcast tag
- cdb_in_value  in  DATA_W  external broadcast value
- res_valid  out  1  registered result broadcast
- res_tag  out  TAG_W  result ROB tag
- res_value  out  DATA_W  result value

## Operation
- Issue: accepted when issue_valid=1, full=0, rdy=1, clear=0, and issue_type is calculation-class. A non-calc type, or issue while full, is silently dropped.
- Allocation: the lowest-index free entry is filled.
- Immediate forms (ADDI…SRAI) take issue_imm as the second operand; vk/qk are ignored and marked ready.
- LUI: result = imm.
- AUIPC: result = pc + imm.
- Shifts use operand2[4:0]. SRA/SRAI are arithmetic. SLT/SLTI compare signed; SLTU/SLTIU compare unsigned. Results are 0/1.
- Wakeup sources: cdb_in and the unit's own res_* port. Every valid pending operand whose tag matches captures the value and clears its pending bit.
- Issue bypass: if an issuing operand's tag matches a broadcast in the same cycle, the entry is written ready with the broadcast value. No wakeup may be lost.
- Dispatch: each cycle the lowest-index entry with both operands ready and valid is executed.
  - The ALU evaluates the dispatched entry combinationally.
  - The result is registered into res_*.
  - The entry is freed in the same cycle.
- No dispatch in a cycle: res_valid=0 next cycle. res_tag and res_value hold their previous values.
- clear (with rdy=1) invalidates all entries and forces res_valid=0 next cycle. It has priority over a simultaneous issue, wakeup and dispatch.

## Timing
- Reset values: all entries invalid, full=0, res_valid=0, res_tag=0, res_value=0.
- Latency: an issue in cycle t with both operands ready can dispatch in t+1, with res_valid high in cycle t+2.
- Back-to-back dependents: a consumer woken by res at t+2 dispatches at t+2, so its result appears at t+3.
- A freed entry is reusable in the cycle after dispatch. full therefore deasserts one cycle after a dispatch from a full station.
- Simultaneous issue and dispatch into a full station is not permitted; full gates issue.
- rdy=0: no state changes and res_* hold. Consumers are stalled by the same rdy.
- Asynchronous reset mid-operation drops all entries immediately.

## Structure
- Shared info header: INST_TYPE_WIDTH, type encodings, and the calculation-class membership list (the same set used by issue-side classification).
- Sub-module alu_core: purely combinational (type, op1, op2, imm, pc) -> result. The station wrapper holds the entry arrays, priority select, wakeup and result register.

## Test plan
- Reset then idle: full=0 and res_valid=0 held for 10 cycles. An issue with type LW is dropped and produces no result.
- Issue ADDI, vj=5, imm=-7, dest=3 at t: res_valid=1, tag=3, value=0xFFFFFFFE at t+2. Likewise SRAI 0x80000000 by 4 gives 0xF8000000, and SLTU 1<2 gives 1.
- Issue SUB with qj=6 pending, then cdb_in tag 6 value 10 two cycles later, with vk=3: result 7 appears two cycles after the broadcast. With cdb_in tag 6 in the same cycle as issue (bypass), the result appears at t+2.
- Chain ADD (dest 1) -> ADDI qj=1: results in consecutive cycles t+2 and t+3.
- Fill all 8 entries with pending operands: full=1 and a 9th issue is dropped. Wake one entry: full drops the cycle after its dispatch.
- clear with entries pending and a dispatch in flight: no res_valid afterwards, full=0. rdy=0 for 3 cycles mid-chain gives identical results delayed by exactly 3 cycles.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared instruction-type definitions for the ALU reservation station.
// The calculation-class membership here matches issue-side classification.
package alu_rs_pkg;

    localparam int INST_TYPE_WIDTH = 6;

    typedef enum logic [INST_TYPE_WIDTH-1:0] {
        I_NOP   = 6'd0,  I_LUI   = 6'd1,  I_AUIPC = 6'd2,  I_JAL   = 6'd3,
        I_JALR  = 6'd4,  I_BEQ   = 6'd5,  I_BNE   = 6'd6,  I_BLT   = 6'd7,
        I_BGE   = 6'd8,  I_BLTU  = 6'd9,  I_BGEU  = 6'd10, I_LB    = 6'd11,
        I_LH    = 6'd12, I_LW    = 6'd13, I_LBU   = 6'd14, I_LHU   = 6'd15,
        I_SB    = 6'd16, I_SH    = 6'd17, I_SW    = 6'd18, I_ADDI  = 6'd19,
        I_SLTI  = 6'd20, I_SLTIU = 6'd21, I_XORI  = 6'd22, I_ORI   = 6'd23,
        I_ANDI  = 6'd24, I_SLLI  = 6'd25, I_SRLI  = 6'd26, I_SRAI  = 6'd27,
        I_ADD   = 6'd28, I_SUB   = 6'd29, I_SLL   = 6'd30, I_SLT   = 6'd31,
        I_SLTU  = 6'd32, I_XOR   = 6'd33, I_SRL   = 6'd34, I_SRA   = 6'd35,
        I_OR    = 6'd36, I_AND   = 6'd37
    } inst_type_e;

    // Register-immediate arithmetic/logic/shift (ADDI..SRAI).
    function automatic logic is_imm_form(input logic [INST_TYPE_WIDTH-1:0] t);
        return (t >= I_ADDI) && (t <= I_SRAI);
    endfunction

    // Register-register arithmetic/logic/shift/compare (ADD..AND).
    function automatic logic is_reg_form(input logic [INST_TYPE_WIDTH-1:0] t);
        return (t >= I_ADD) && (t <= I_AND);
    endfunction

    // Everything this station accepts.
    function automatic logic is_calc(input logic [INST_TYPE_WIDTH-1:0] t);
        return (t == I_LUI) || (t == I_AUIPC) || is_imm_form(t) || is_reg_form(t);
    endfunction

endpackage

// File: rtl/alu_rs_alu_core.sv
// Combinational integer ALU: (type, op1, op2, imm, pc) -> result.
// For immediate forms the station already presents the immediate as op2.
module alu_core
    import alu_rs_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [INST_TYPE_WIDTH-1:0] itype,
    input  logic [DATA_W-1:0]          op1,
    input  logic [DATA_W-1:0]          op2,
    input  logic [DATA_W-1:0]          imm,
    input  logic [DATA_W-1:0]          pc,
    output logic [DATA_W-1:0]          result
);

    logic [4:0] shamt;
    assign shamt = op2[4:0];

    // Select the operation for the dispatched instruction type
    always_comb begin
        result = '0;
        case (inst_type_e'(itype))
            I_LUI:           result = imm;
            I_AUIPC:         result = pc + imm;
            I_ADDI, I_ADD:   result = op1 + op2;
            I_SUB:           result = op1 - op2;
            I_SLTI, I_SLT:   result = {{(DATA_W-1){1'b0}}, $signed(op1) < $signed(op2)};
            I_SLTIU, I_SLTU: result = {{(DATA_W-1){1'b0}}, op1 < op2};
            I_XORI, I_XOR:   result = op1 ^ op2;
            I_ORI, I_OR:     result = op1 | op2;
            I_ANDI, I_AND:   result = op1 & op2;
            I_SLLI, I_SLL:   result = op1 << shamt;
            I_SRLI, I_SRL:   result = op1 >> shamt;
            I_SRAI, I_SRA:   result = $signed(op1) >>> shamt;
            default:         result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rs.sv
// Reservation station + single-issue ALU. Holds calc-class instructions until
// both operands are ready (snooping cdb_in and its own result port), then
// dispatches the lowest-index ready entry and registers the tagged result.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE = 8,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rdy,
    input  logic                       clear,
    input  logic                       issue_valid,
    input  logic [INST_TYPE_WIDTH-1:0] issue_type,
    input  logic [DATA_W-1:0]          issue_vj,
    input  logic [DATA_W-1:0]          issue_vk,
    input  logic                       issue_qj_pend,
    input  logic                       issue_qk_pend,
    input  logic [TAG_W-1:0]           issue_qj,
    input  logic [TAG_W-1:0]           issue_qk,
    input  logic [DATA_W-1:0]          issue_imm,
    input  logic [DATA_W-1:0]          issue_pc,
    input  logic [TAG_W-1:0]           issue_dest,
    output logic                       full,
    input  logic                       cdb_in_valid,
    input  logic [TAG_W-1:0]           cdb_in_tag,
    input  logic [DATA_W-1:0]          cdb_in_value,
    output logic                       res_valid,
    output logic [TAG_W-1:0]           res_tag,
    output logic [DATA_W-1:0]          res_value
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // Entry state
    logic [RS_SIZE-1:0]         valid, qj_pend, qk_pend;
    logic [INST_TYPE_WIDTH-1:0] e_type [RS_SIZE];
    logic [DATA_W-1:0]          e_vj   [RS_SIZE];
    logic [DATA_W-1:0]          e_vk   [RS_SIZE];
    logic [DATA_W-1:0]          e_imm  [RS_SIZE];
    logic [DATA_W-1:0]          e_pc   [RS_SIZE];
    logic [TAG_W-1:0]           e_qj   [RS_SIZE];
    logic [TAG_W-1:0]           e_qk   [RS_SIZE];
    logic [TAG_W-1:0]           e_dest [RS_SIZE];

    // Wakeup / dispatch view
    logic [RS_SIZE-1:0] wake_j, wake_k, fwd_j, fwd_k, ready;
    logic [DATA_W-1:0]  wake_vj [RS_SIZE];
    logic [DATA_W-1:0]  wake_vk [RS_SIZE];
    logic [DATA_W-1:0]  op1     [RS_SIZE];
    logic [DATA_W-1:0]  op2     [RS_SIZE];
    logic [IDX_W-1:0]   free_idx, disp_idx;
    logic               disp_found;
    logic [DATA_W-1:0]  alu_result;

    // Issue view
    logic              iss_ok, iss_qj_pend, iss_qk_pend;
    logic [DATA_W-1:0] iss_vj, iss_vk;

    assign full = &valid;

    // Per-entry wakeup from either broadcast, and same-cycle forwarding of our
    // own result so a dependent can dispatch in the cycle the result appears
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            // NOTE: every output gets a default before any condition so this block cannot infer latches.
            wake_j[i]  = 1'b0;
            wake_k[i]  = 1'b0;
            wake_vj[i] = e_vj[i];
            wake_vk[i] = e_vk[i];
            if (qj_pend[i]) begin
                if (cdb_in_valid && cdb_in_tag == e_qj[i]) begin
                    wake_j[i]  = 1'b1;
                    wake_vj[i] = cdb_in_value;
                end else if (res_valid && res_tag == e_qj[i]) begin
                    wake_j[i]  = 1'b1;
                    wake_vj[i] = res_value;
                end
            end
            if (qk_pend[i]) begin
                if (cdb_in_valid && cdb_in_tag == e_qk[i]) begin
                    wake_k[i]  = 1'b1;
                    wake_vk[i] = cdb_in_value;
                end else if (res_valid && res_tag == e_qk[i]) begin
                    wake_k[i]  = 1'b1;
                    wake_vk[i] = res_value;
                end
            end
            fwd_j[i] = qj_pend[i] && res_valid && (res_tag == e_qj[i]);
            fwd_k[i] = qk_pend[i] && res_valid && (res_tag == e_qk[i]);
            op1[i]   = fwd_j[i] ? res_value : e_vj[i];
            op2[i]   = fwd_k[i] ? res_value : e_vk[i];
            ready[i] = valid[i] && (!qj_pend[i] || fwd_j[i]) && (!qk_pend[i] || fwd_k[i]);
        end
    end

    // Lowest-index free slot and lowest-index ready slot (scan downward so the lowest wins)
    always_comb begin
        free_idx   = '0;
        disp_idx   = '0;
        disp_found = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid[i]) free_idx = IDX_W'(i);
            if (ready[i]) begin
                disp_idx   = IDX_W'(i);
                disp_found = 1'b1;
            end
        end
    end

    // Classify the issuing instruction and resolve its operands, including bypass
    // from a broadcast in the same cycle so no wakeup is missed
    always_comb begin
        iss_ok      = issue_valid && !full && rdy && !clear && is_calc(issue_type);
        iss_qj_pend = 1'b0;
        iss_qk_pend = 1'b0;
        iss_vj      = issue_vj;
        iss_vk      = issue_vk;
        if ((is_imm_form(issue_type) || is_reg_form(issue_type)) && issue_qj_pend) begin
            if (cdb_in_valid && cdb_in_tag == issue_qj)   iss_vj = cdb_in_value;
            else if (res_valid && res_tag == issue_qj)    iss_vj = res_value;
            else                                          iss_qj_pend = 1'b1;
        end
        if (is_imm_form(issue_type)) begin
            iss_vk = issue_imm;
        end else if (is_reg_form(issue_type) && issue_qk_pend) begin
            if (cdb_in_valid && cdb_in_tag == issue_qk)   iss_vk = cdb_in_value;
            else if (res_valid && res_tag == issue_qk)    iss_vk = res_value;
            else                                          iss_qk_pend = 1'b1;
        end
    end

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .itype  (e_type[disp_idx]),
        .op1    (op1[disp_idx]),
        .op2    (op2[disp_idx]),
        .imm    (e_imm[disp_idx]),
        .pc     (e_pc[disp_idx]),
        .result (alu_result)
    );

    // Occupancy, pending bits and the registered result broadcast
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= '0;
            qj_pend   <= '0;
            qk_pend   <= '0;
            res_valid <= 1'b0;
            res_tag   <= '0;
            res_value <= '0;
        end else if (rdy) begin
            if (clear) begin
                valid     <= '0;
                res_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (wake_j[i]) qj_pend[i] <= 1'b0;
                    if (wake_k[i]) qk_pend[i] <= 1'b0;
                end
                if (disp_found) valid[disp_idx] <= 1'b0;
                // NOTE: the last non-blocking write to a bit wins, so the issue below overrides any stale wakeup on the free slot.
                if (iss_ok) begin
                    valid[free_idx]   <= 1'b1;
                    qj_pend[free_idx] <= iss_qj_pend;
                    qk_pend[free_idx] <= iss_qk_pend;
                end
                res_valid <= disp_found;
                if (disp_found) begin
                    res_tag   <= e_dest[disp_idx];
                    res_value <= alu_result;
                end
            end
        end
    end

    // Entry payload: captured wakeup values and issued fields
    // NOTE: payload arrays are deliberately not reset; fields are only consumed while the entry's valid bit is set.
    always_ff @(posedge clk) begin
        if (rdy && !clear) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (wake_j[i]) e_vj[i] <= wake_vj[i];
                if (wake_k[i]) e_vk[i] <= wake_vk[i];
            end
            if (iss_ok) begin
                e_type[free_idx] <= issue_type;
                e_vj[free_idx]   <= iss_vj;
                e_vk[free_idx]   <= iss_vk;
                e_qj[free_idx]   <= issue_qj;
                e_qk[free_idx]   <= issue_qk;
                e_imm[free_idx]  <= issue_imm;
                e_pc[free_idx]   <= issue_pc;
                e_dest[free_idx] <= issue_dest;
            end
        end
    end

endmodule
